// File: rtl/vga_scan_if.sv
// Video-side bundle between the VGA scanner, the VRAM read port and the pins.
// The scanner owns the master side; VRAM and pins sit on the slave side.
interface vga_scan_if;
   logic        vram_load;
   logic [12:0] vram_addr;
   logic [11:0] vram_data;
   logic [3:0]  vga_r;
   logic [3:0]  vga_g;
   logic [3:0]  vga_b;
   logic        vga_hs;
   logic        vga_vs;
   logic        frame_start;

   modport master (
      output vram_load, vram_addr,
      input  vram_data,
      output vga_r, vga_g, vga_b, vga_hs, vga_vs, frame_start
   );

   modport slave (
      input  vram_load, vram_addr,
      output vram_data,
      input  vga_r, vga_g, vga_b, vga_hs, vga_vs, frame_start
   );
endinterface

// File: rtl/vga_scan.sv
// 640x480@60 VGA scanner: free-running pixel counters, 8x8-block VRAM fetch
// and one-pixel registered RGB/sync outputs that stay mutually aligned.
module vga_scan #(
   parameter int CLK_DIV = 4,
   parameter int H_VIS   = 640,
   parameter int H_FP    = 16,
   parameter int H_SYNC  = 96,
   parameter int H_BP    = 48,
   parameter int V_VIS   = 480,
   parameter int V_FP    = 10,
   parameter int V_SYNC  = 2,
   parameter int V_BP    = 33
) (
   input  logic        clk,
   input  logic        rst,
   vga_scan_if.master  vga
);

   localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
   localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;
   localparam int HW    = $clog2(H_TOT);
   localparam int VW    = $clog2(V_TOT);
   localparam int PW    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   localparam logic [PW-1:0] PIX_LAST = PW'(CLK_DIV - 1);
   localparam logic [HW-1:0] H_LAST   = HW'(H_TOT - 1);
   localparam logic [VW-1:0] V_LAST   = VW'(V_TOT - 1);
   localparam logic [HW-1:0] H_VIS_C  = HW'(H_VIS);
   localparam logic [VW-1:0] V_VIS_C  = VW'(V_VIS);
   localparam logic [HW-1:0] HS_BEG   = HW'(H_VIS + H_FP);
   localparam logic [HW-1:0] HS_END   = HW'(H_VIS + H_FP + H_SYNC);
   localparam logic [VW-1:0] VS_BEG   = VW'(V_VIS + V_FP);
   localparam logic [VW-1:0] VS_END   = VW'(V_VIS + V_FP + V_SYNC);

   logic [PW-1:0] pre;
   logic [HW-1:0] h_cnt;
   logic [VW-1:0] v_cnt;
   logic          pix_tick;
   logic          h_end;
   logic          v_end;
   logic          visible;
   logic          in_hs;
   logic          in_vs;

   logic [11:0]   rgb_p1;
   logic          hs_p1;
   logic          vs_p1;

   // 80 cells per row; the *80 is built from two shifts so no multiplier is inferred.
   function automatic logic [12:0] cell_addr(input logic [HW-1:0] h, input logic [VW-1:0] v);
      logic [12:0] row;
      logic [12:0] col;
      row = 13'(v >> 3);
      col = 13'(h >> 3);
      return (row << 6) + (row << 4) + col;
   endfunction

   assign pix_tick = (pre == PIX_LAST);
   assign h_end    = (h_cnt == H_LAST);
   assign v_end    = (v_cnt == V_LAST);
   assign visible  = (h_cnt < H_VIS_C) && (v_cnt < V_VIS_C);
   assign in_hs    = (h_cnt >= HS_BEG) && (h_cnt < HS_END);
   assign in_vs    = (v_cnt >= VS_BEG) && (v_cnt < VS_END);

   // ---- stage p0: prescaler and raster counters
   always_ff @(posedge clk) begin
      if (rst) begin
         pre   <= '0;
         h_cnt <= '0;
         v_cnt <= '0;
      end else begin
         if (pix_tick) begin
            pre <= '0;
            if (h_end) begin
               h_cnt <= '0;
               v_cnt <= v_end ? '0 : v_cnt + 1'b1;
            end else begin
               h_cnt <= h_cnt + 1'b1;
            end
         end else begin
            pre <= pre + 1'b1;
         end
      end
   end

   // VRAM answers combinationally, so the request is driven from the live counters.
   assign vga.vram_load = visible;
   assign vga.vram_addr = visible ? cell_addr(h_cnt, v_cnt) : 13'd0;

   // ---- stage p1: colour and sync registered together on the pixel tick
   always_ff @(posedge clk) begin
      if (rst) begin
         rgb_p1 <= 12'h000;
         hs_p1  <= 1'b1;
         vs_p1  <= 1'b1;
      end else if (pix_tick) begin
         rgb_p1 <= visible ? vga.vram_data : 12'h000;
         hs_p1  <= !in_hs;
         vs_p1  <= !in_vs;
      end
   end

   assign vga.vga_r       = rgb_p1[11:8];
   assign vga.vga_g       = rgb_p1[7:4];
   assign vga.vga_b       = rgb_p1[3:0];
   assign vga.vga_hs      = hs_p1;
   assign vga.vga_vs      = vs_p1;
   assign vga.frame_start = !rst && pix_tick && h_end && v_end;

endmodule

// File: tb/tb_vga_scan.sv
// Directed bench: a CLK_DIV=1 scanner with a short frame and a CLK_DIV=4
// scanner with full 640x480 timing, both sharing clk and rst.
module tb_vga_scan;

   logic clk;
   logic rst;
   int   cyc;
   int   n_chk;
   int   n_pass;

   vga_scan_if ifa ();
   vga_scan_if ifb ();

   vga_scan #(
      .CLK_DIV(1), .H_VIS(640), .H_FP(16), .H_SYNC(96), .H_BP(48),
      .V_VIS(16), .V_FP(2), .V_SYNC(2), .V_BP(2)
   ) dut_a (
      .clk(clk),
      .rst(rst),
      .vga(ifa)
   );

   vga_scan dut_b (
      .clk(clk),
      .rst(rst),
      .vga(ifb)
   );

   // Address-dependent VRAM model for dut_a, saturated white for dut_b.
   assign ifa.vram_data = ifa.vram_addr[11:0] + 12'h123;
   assign ifb.vram_data = 12'hFFF;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (rst) cyc <= 0;
      else     cyc <= cyc + 1;
   end

   task automatic chk(input string tag, input int obs, input int exp);
      n_chk++;
      if (obs == exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
   endtask

   task automatic wait_cyc(input int k);
      int g;
      g = 0;
      while (cyc != k && g < 100000) begin
         @(negedge clk);
         g++;
      end
      if (cyc != k) chk("wait_cyc", cyc, k);
   endtask

   function automatic int rgb_a();
      return int'({ifa.vga_r, ifa.vga_g, ifa.vga_b});
   endfunction

   function automatic int rgb_b();
      return int'({ifb.vga_r, ifb.vga_g, ifb.vga_b});
   endfunction

   initial begin
      int lo;
      int fs_n;
      int fs_k;
      n_chk  = 0;
      n_pass = 0;
      rst    = 1'b1;
      repeat (3) @(negedge clk);

      chk("rst_rgb_a", rgb_a(), 0);
      chk("rst_hs_a", int'(ifa.vga_hs), 1);
      chk("rst_vs_a", int'(ifa.vga_vs), 1);
      chk("rst_fs_a", int'(ifa.frame_start), 0);
      chk("rst_rgb_b", rgb_b(), 0);
      chk("rst_hs_b", int'(ifb.vga_hs), 1);
      chk("rst_vs_b", int'(ifb.vga_vs), 1);
      chk("rst_fs_b", int'(ifb.frame_start), 0);

      rst = 1'b0;
      chk("c0_load_a", int'(ifa.vram_load), 1);
      chk("c0_addr_a", int'(ifa.vram_addr), 0);
      chk("c0_load_b", int'(ifb.vram_load), 1);
      chk("c0_addr_b", int'(ifb.vram_addr), 0);

      wait_cyc(3);    chk("b_rgb_pre_tick", rgb_b(), 12'h000);
      wait_cyc(4);    chk("b_rgb_first_tick", rgb_b(), 12'hFFF);
      wait_cyc(8);    chk("a_addr_h8v0", int'(ifa.vram_addr), 1);
      wait_cyc(9);    chk("a_rgb_h8v0", rgb_a(), 12'h124);
      wait_cyc(31);   chk("b_addr_h7", int'(ifb.vram_addr), 0);
      wait_cyc(32);   chk("b_addr_h8", int'(ifb.vram_addr), 1);
      wait_cyc(640);
      chk("a_rgb_h639v0", rgb_a(), 12'h172);
      chk("a_load_h640", int'(ifa.vram_load), 0);
      chk("a_addr_h640", int'(ifa.vram_addr), 0);
      wait_cyc(641);  chk("a_rgb_hblank", rgb_a(), 12'h000);
      wait_cyc(656);  chk("a_hs_before", int'(ifa.vga_hs), 1);
      wait_cyc(657);  chk("a_hs_start", int'(ifa.vga_hs), 0);
      wait_cyc(752);  chk("a_hs_last", int'(ifa.vga_hs), 0);
      wait_cyc(753);  chk("a_hs_end", int'(ifa.vga_hs), 1);

      lo = 0;
      for (int k = 801; k <= 1600; k++) begin
         wait_cyc(k);
         if (!ifa.vga_hs) lo++;
      end
      chk("a_hs_width", lo, 96);

      wait_cyc(2560); chk("b_rgb_h639", rgb_b(), 12'hFFF);
      wait_cyc(2564); chk("b_rgb_h640", rgb_b(), 12'h000);
      wait_cyc(2627); chk("b_hs_before", int'(ifb.vga_hs), 1);
      wait_cyc(2628); chk("b_hs_start", int'(ifb.vga_hs), 0);
      wait_cyc(3011); chk("b_hs_last", int'(ifb.vga_hs), 0);
      wait_cyc(3012); chk("b_hs_end", int'(ifb.vga_hs), 1);
      wait_cyc(5607);
      chk("a_load_h7v7", int'(ifa.vram_load), 1);
      chk("a_addr_h7v7", int'(ifa.vram_addr), 0);
      wait_cyc(5827); chk("b_hs_line1_before", int'(ifb.vga_hs), 1);
      wait_cyc(5828); chk("b_hs_line1_start", int'(ifb.vga_hs), 0);
      wait_cyc(6400); chk("a_addr_h0v8", int'(ifa.vram_addr), 80);
      wait_cyc(6401); chk("a_rgb_h0v8", rgb_a(), 12'h173);
      wait_cyc(12639); chk("a_addr_h639v15", int'(ifa.vram_addr), 159);
      wait_cyc(12640); chk("a_rgb_h639v15", rgb_a(), 12'h1C2);
      wait_cyc(12641); chk("a_rgb_h640v15", rgb_a(), 12'h000);
      wait_cyc(12800);
      chk("a_load_vblank", int'(ifa.vram_load), 0);
      chk("a_addr_vblank", int'(ifa.vram_addr), 0);
      wait_cyc(12801); chk("a_rgb_vblank", rgb_a(), 12'h000);
      wait_cyc(14400); chk("a_vs_before", int'(ifa.vga_vs), 1);
      wait_cyc(14401); chk("a_vs_start", int'(ifa.vga_vs), 0);
      wait_cyc(16000); chk("a_vs_last", int'(ifa.vga_vs), 0);
      wait_cyc(16001); chk("a_vs_end", int'(ifa.vga_vs), 1);
      wait_cyc(17598); chk("a_fs_before", int'(ifa.frame_start), 0);
      wait_cyc(17599); chk("a_fs_pulse", int'(ifa.frame_start), 1);
      wait_cyc(17600); chk("a_fs_after", int'(ifa.frame_start), 0);

      fs_n = 0;
      fs_k = -1;
      for (int k = 17601; k <= 35300; k++) begin
         wait_cyc(k);
         if (ifa.frame_start) begin
            fs_n++;
            fs_k = k;
         end
      end
      chk("a_fs_count", fs_n, 1);
      chk("a_fs_period", fs_k, 35199);

      // Land a reset in the middle of an hsync pulse (h_cnt = 700).
      wait_cyc(35900);
      chk("a_hs_mid", int'(ifa.vga_hs), 0);
      rst = 1'b1;
      @(negedge clk);
      chk("mid_rst_hs", int'(ifa.vga_hs), 1);
      chk("mid_rst_addr", int'(ifa.vram_addr), 0);
      chk("mid_rst_rgb", rgb_a(), 0);
      chk("mid_rst_fs", int'(ifa.frame_start), 0);
      rst = 1'b0;
      wait_cyc(656); chk("rerun_hs_before", int'(ifa.vga_hs), 1);
      wait_cyc(657); chk("rerun_hs_start", int'(ifa.vga_hs), 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/vga_scan.md
Name: vga_scan

Overview:
- Display-side consumer of the video RAM.
- Generates 640x480@60 VGA timing from the system clock.
- Drives the VRAM read port (address + load) and registers the returned 12-bit RGB444 word onto the VGA pins.
- Each of the 80x60 VRAM cells is shown as an 8x8 pixel block.
- The VRAM read path is combinational, so address-to-data is same-cycle.

Parameters:
- CLK_DIV, 4, system clocks per pixel (100 MHz -> 25 MHz); legal values are 1 and above.
- H_VIS, 640, visible pixels per line.
- H_FP, 16, horizontal front porch.
- H_SYNC, 96, horizontal sync width.
- H_BP, 48, horizontal back porch.
- V_VIS, 480, visible lines.
- V_FP, 10, vertical front porch.
- V_SYNC, 2, vertical sync width.
- V_BP, 33, vertical back porch.

Ports:
- clk  input  1  system clock
- rst  input  1  reset
- vram_load  output  1  VRAM read enable
- vram_addr  output  13  VRAM read address
- vram_data  input  12  RGB444 from VRAM {R[11:8],G[7:4],B[3:0]}
- vga_r  output  4  red
- vga_g  output  4  green
- vga_b  output  4  blue
- vga_hs  output  1  horizontal sync, active low
- vga_vs  output  1  vertical sync, active low
- frame_start  output  1  one-clk pulse at frame wrap

Behaviour:
- Clock/reset: one clock (clk); rst is synchronous and active-high.
- Reset values:
  - Prescaler, h_cnt and v_cnt = 0.
  - vga_r/g/b = 0; vga_hs = 1; vga_vs = 1; frame_start = 0.
- Reset mid-frame: takes effect on the next clk edge; the scan restarts at (0,0) with no partial sync pulse held.
- Prescaler: counts 0..CLK_DIV-1 and wraps. pix_tick = (prescaler == CLK_DIV-1). With CLK_DIV=1, pix_tick is high every cycle.
- Counters (advance only on pix_tick):
  - H_TOT = H_VIS+H_FP+H_SYNC+H_BP (800). V_TOT = V_VIS+V_FP+V_SYNC+V_BP (525).
  - h_cnt 0..H_TOT-1; on wrap, h_cnt returns to 0 and v_cnt increments.
  - v_cnt 0..V_TOT-1, wrapping to 0 at the end of line H_TOT-1 of line V_TOT-1.
- Visible region: visible = (h_cnt < H_VIS) && (v_cnt < V_VIS).
- VRAM request (combinational from the current counters):
  - vram_load = visible.
  - vram_addr = (v_cnt>>3)*80 + (h_cnt>>3) when visible, else 0.
  - Multiply implemented as (row<<6)+(row<<4); no multiplier.
  - Maximum address 59*80+79 = 4799, which fits 13 bits.
- Output register (updates only on pix_tick):
  - {vga_r,vga_g,vga_b} <= visible ? vram_data : 12'h000.
  - vga_hs <= !(h_cnt >= H_VIS+H_FP && h_cnt < H_VIS+H_FP+H_SYNC).
  - vga_vs <= !(v_cnt >= V_VIS+V_FP && v_cnt < V_VIS+V_FP+V_SYNC).
  - Colour, hs and vs therefore share the same one-pixel latency relative to the counters and stay mutually aligned.
  - Between ticks all outputs hold their value.
- frame_start: high for exactly one clk on the pix_tick where h_cnt = H_TOT-1 and v_cnt = V_TOT-1; low otherwise, including during reset.
- Blanking: RGB is forced to 0 outside the visible region regardless of vram_data. vram_data is ignored when vram_load = 0.
- No backpressure or stall: the scan is free-running.

Test Plan:
- Reset then release, CLK_DIV=4 -> outputs at reset values; vram_load=1, vram_addr=0 at cycle 0; first h_cnt increment after 4 clks.
- Line timing -> vga_hs low for exactly 96 pixel ticks (384 clks), starting 656 ticks after line start; line period 3200 clks.
- Frame timing -> vga_vs low for 2 lines (6400 clks) starting at line 490; frame_start pulses once per 1,680,000 clks, one clk wide.
- Address mapping with a VRAM model returning addr-dependent data:
  - (h=7,v=7) -> addr 0.
  - (h=8,v=0) -> addr 1.
  - (h=0,v=8) -> addr 80.
  - (h=639,v=479) -> addr 4799.
  - RGB matches the model one pixel tick later.
- Blanking: vram_data tied to 12'hFFF -> RGB = FFF only while visible (one tick delayed); RGB = 000 during h_cnt 640..799 and v_cnt 480..524; vram_load = 0 and vram_addr = 0 there.
- Reset mid-line at h_cnt=700 (inside hsync) -> vga_hs = 1 on the next clk; counters restart at 0; the next hsync appears 656 ticks later.
